// File: rtl/mx4_rr_arbiter.sv
// mx4_rr_arbiter: round-robin arbiter/sequencer for a 4:1 4-bit output mux.
// Grants one requester at a time for a burst of up to MAX_BURST accepted words.
// The mux select and enable are driven from registered state, and there is a
// valid/ready handshake toward the consumer. One IDLE bubble separates grants.
// Optional build macro: MX4ARB_PRIO0_EN gives requester 0 strict high priority.
// In that build, requesters 1-3 stay round-robin among themselves.
module mx4_rr_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       out_ready,
  output logic [3:0] gnt,
  output logic [1:0] mux_sel,
  output logic       mux_en,
  output logic       out_valid,
  output logic       xfer
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] burst_q, burst_d;
  logic [1:0]    last_q, last_d;
  logic [3:0]    gnt_d;
  logic [1:0]    sel_d;
  logic          en_d;
  logic [1:0]    win;
  logic          win_vld;
  logic          rel;

  // Handshake: valid only while enabled and the granted requester still holds a word.
  assign out_valid = mux_en & req[mux_sel];
  assign xfer      = out_valid & out_ready;

  // Winner scan: first set request after the last released index, wrapping mod 4.
  always_comb begin
    logic [1:0] cand;
    win     = last_q;
    win_vld = 1'b0;
    cand    = 2'd0;
`ifdef MX4ARB_PRIO0_EN
    if (req[0]) begin
      win     = 2'd0;
      win_vld = 1'b1;
    end else begin
      // Rotate through 1..3 only; last_q never holds 0 in this build.
      for (int k = 1; k <= 3; k++) begin
        cand = 2'(((int'(last_q) - 1 + k) % 3) + 1);
        if (!win_vld && req[cand]) begin
          win     = cand;
          win_vld = 1'b1;
        end
      end
    end
`else
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!win_vld && req[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
`endif
  end

  // Next-state and next-output logic for the IDLE/BUSY sequencer.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    sel_d   = mux_sel;
    en_d    = mux_en;
    burst_d = burst_q;
    last_d  = last_q;
    rel     = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = BUSY;
          sel_d   = win;
          gnt_d   = 4'b0001 << win;
          en_d    = 1'b1;
          burst_d = '0;
        end
      end
      BUSY: begin
        if (xfer && (burst_q == LAST_CNT)) begin
          rel = 1'b1;
        end else if (!req[mux_sel]) begin
          rel = 1'b1;
`ifdef MX4ARB_PRIO0_EN
        end else if (xfer && (mux_sel != 2'd0) && req[0]) begin
          // A pending requester 0 cuts the current burst short.
          rel = 1'b1;
`endif
        end else if (xfer) begin
          burst_d = burst_q + CW'(1);
        end
        if (rel) begin
          state_d = IDLE;
          gnt_d   = '0;
          en_d    = 1'b0;
          burst_d = '0;
`ifdef MX4ARB_PRIO0_EN
          if (mux_sel != 2'd0) last_d = mux_sel;
`else
          last_d = mux_sel;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; last resets to 3 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt     <= '0;
      mux_sel <= '0;
      mux_en  <= 1'b0;
      burst_q <= '0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      mux_sel <= sel_d;
      mux_en  <= en_d;
      burst_q <= burst_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_mx4_rr_arbiter.sv
// tb_mx4_rr_arbiter: directed-vector bench for mx4_rr_arbiter.
// It drives inputs 1 time unit after the rising edge and checks against hand-computed values.
// A second instance with MAX_BURST=1 covers the single-word burst case.
module tb_mx4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic       out_ready = 1'b0;
  logic [3:0] gnt, gnt1;
  logic [1:0] mux_sel, mux_sel1;
  logic       mux_en, mux_en1, out_valid, out_valid1, xfer, xfer1;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mx4_rr_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .gnt(gnt), .mux_sel(mux_sel), .mux_en(mux_en),
    .out_valid(out_valid), .xfer(xfer)
  );

  mx4_rr_arbiter #(.MAX_BURST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .gnt(gnt1), .mux_sel(mux_sel1), .mux_en(mux_en1),
    .out_valid(out_valid1), .xfer(xfer1)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req       = '0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_sel", mux_sel, 0);
    chk("rst_en", mux_en, 0);
    chk("rst_valid", out_valid, 0);
    do_reset();

    // Full contention: grants 0,1,2,3,0 with 4 words each and a bubble between
    req = 4'b1111; out_ready = 1'b1;
    tick();
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("rr_gnt%0d", g), gnt, 1 << (g % 4));
      chk($sformatf("rr_sel%0d", g), mux_sel, g % 4);
      for (int w = 0; w < 4; w++) begin
        chk($sformatf("rr_xfer%0d_%0d", g, w), xfer, 1);
        tick();
      end
      chk($sformatf("rr_bub_gnt%0d", g), gnt, 0);
      chk($sformatf("rr_bub_vld%0d", g), out_valid, 0);
      tick();
    end

    // Async reset mid-BUSY (requester 1 granted now)
    chk("pre_rst_gnt", gnt, 4'b0010);
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", gnt, 0);
    chk("arst_en", mux_en, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_xfer", xfer, 0);
    tick();
    rst_n = 1'b1;

    // Single requester with a stalling consumer
    do_reset();
    req = 4'b0100;
    tick();
    for (int c = 0; c < 7; c++) begin
      out_ready = (c % 2 == 0);
      #1;
      chk($sformatf("stall_gnt%0d", c), gnt, 4'b0100);
      chk($sformatf("stall_xfer%0d", c), xfer, (c % 2 == 0) ? 1 : 0);
      tick();
    end
    chk("stall_rel", gnt, 0);
    tick();
    chk("stall_regnt", gnt, 4'b0100);

    // Requester 1 drops after 2 words; requester 2 then gets a full burst
    do_reset();
    req = 4'b0110; out_ready = 1'b1;
    tick();
    chk("drop_gnt", gnt, 4'b0010);
    for (int w = 0; w < 2; w++) begin
      chk($sformatf("drop_xfer%0d", w), xfer, 1);
      tick();
    end
    req = 4'b0100;
    #1;
    chk("drop_noxfer", xfer, 0);
    chk("drop_hold", gnt, 4'b0010);
    tick();
    chk("drop_rel", gnt, 0);
    chk("drop_en", mux_en, 0);
    tick();
    chk("drop_next", gnt, 4'b0100);
    chk("drop_nsel", mux_sel, 2);
    for (int w = 0; w < 4; w++) begin
      chk($sformatf("drop_b2_%0d", w), xfer, 1);
      tick();
    end
    chk("drop_b2_rel", gnt, 0);

    // Consumer never ready: grant held, no rotation
    do_reset();
    req = 4'b0011; out_ready = 1'b0;
    tick();
    for (int c = 0; c < 20; c++) begin
      if (gnt != 4'b0001 || xfer != 1'b0) begin
        chk($sformatf("hold_gnt%0d", c), gnt, 4'b0001);
        chk($sformatf("hold_xfer%0d", c), xfer, 0);
      end
      tick();
    end
    chk("hold_gnt_end", gnt, 4'b0001);
    chk("hold_valid", out_valid, 1);
    chk("hold_xfer", xfer, 0);

    // Requester 0 rising while requester 3 is busy
    do_reset();
    req = 4'b1000; out_ready = 1'b1;
    tick();
    chk("p0_gnt3", gnt, 4'b1000);
    chk("p0_x1", xfer, 1);
    tick();
    req = 4'b1001; out_ready = 1'b0;
    #1;
    chk("p0_stall", xfer, 0);
    tick();
    chk("p0_held", gnt, 4'b1000);
    out_ready = 1'b1;
    #1;
    chk("p0_x2", xfer, 1);
    tick();
`ifdef MX4ARB_PRIO0_EN
    chk("p0_cut", gnt, 0);
    tick();
    chk("p0_win", gnt, 4'b0001);
`else
    chk("p0_keep", gnt, 4'b1000);
    tick();
    chk("p0_keep2", gnt, 4'b1000);
`endif

    // MAX_BURST=1: every accepted word releases the grant
    do_reset();
    req = 4'b0110; out_ready = 1'b1;
    tick();
    chk("mb1_gnt", gnt1, 4'b0010);
    chk("mb1_xfer", xfer1, 1);
    tick();
    chk("mb1_rel", gnt1, 0);
    tick();
    chk("mb1_next", gnt1, 4'b0100);
    chk("mb1_sel", mux_sel1, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
